// File: rtl/sla_iter.sv
// -----------------------------------------------------------------------------
// sla_iter -- iterative arithmetic shift-left with signed saturation.
//
// Accepts one signed WIDTH-bit operand and a shift amount per transaction,
// shifts it left by at most STEP bits per clock and returns the result. If
// the shifted value would leave the signed range, the result is clamped to
// the most positive or most negative value and out_sat is flagged.
// Latency is fixed by the shift amount alone: ceil(shamt/STEP) shift cycles
// plus one cycle into the result state. Saturation does not shorten it.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand valid
//   in_ready   out  block can accept an operand (IDLE only)
//   in_data    in   signed operand, WIDTH bits
//   in_shamt   in   left-shift amount, SHW bits
//   out_valid  out  result valid
//   out_ready  in   downstream accepts the result
//   out_data   out  shifted / saturated result
//   out_sat    out  result was saturated
//   busy       out  high while shifting or holding a result
// -----------------------------------------------------------------------------
module sla_iter #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5,
   parameter int STEP  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_sat,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state_q;
   logic [WIDTH-1:0] value_q, value_d;
   logic [SHW-1:0]   rem_q, rem_d;
   logic             sign_q;
   logic             sat_q, sat_d;

   logic             in_ready_q;
   logic             busy_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic             out_sat_q;

   logic [SHW-1:0]   k;
   logic [STEP:0]    ovf_vec;
   logic             ovf;

   // Bits consumed this cycle: the smaller of the remaining count and STEP.
   always_comb begin
      if (32'(rem_q) < STEP) begin
         k = rem_q;
      end else begin
         k = SHW'(STEP);
      end
   end

   // ovf_vec[n] flags that a shift by n would lose significance: the top
   // n+1 bits of the current value are not all copies of the sign bit.
   // A shift by zero can never overflow, so ovf_vec[0] is constant 0.
   genvar gi;
   generate
      for (gi = 0; gi <= STEP; gi++) begin : g_ovf
         logic [gi:0] top;
         assign top         = value_q[WIDTH-1 -: gi+1];
         assign ovf_vec[gi] = ~((&top) | ~(|top));
      end
   endgenerate

   always_comb begin
      ovf = 1'b0;
      for (int i = 0; i <= STEP; i++) begin
         if (32'(k) == i) begin
            ovf = ovf_vec[i];
         end
      end
   end

   // One shift step. Once saturated the value is frozen, but the remaining
   // count still runs down so latency depends only on the shift amount.
   always_comb begin
      value_d = value_q;
      sat_d   = sat_q;
      rem_d   = rem_q - k;
      if (!sat_q) begin
         if (ovf) begin
            sat_d   = 1'b1;
            value_d = sign_q ? SAT_NEG : SAT_POS;
         end else begin
            value_d = value_q << k;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         value_q     <= '0;
         rem_q       <= '0;
         sign_q      <= 1'b0;
         sat_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  value_q    <= in_data;
                  rem_q      <= in_shamt;
                  sign_q     <= in_data[WIDTH-1];
                  sat_q      <= 1'b0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  if (in_shamt == '0) begin
                     // Nothing to shift: present the operand unchanged.
                     state_q     <= S_DONE;
                     out_valid_q <= 1'b1;
                     out_data_q  <= in_data;
                     out_sat_q   <= 1'b0;
                  end else begin
                     state_q <= S_SHIFT;
                  end
               end
            end

            S_SHIFT: begin
               value_q <= value_d;
               sat_q   <= sat_d;
               rem_q   <= rem_d;
               if (rem_d == '0) begin
                  state_q     <= S_DONE;
                  out_valid_q <= 1'b1;
                  out_data_q  <= value_d;
                  out_sat_q   <= sat_d;
               end
            end

            S_DONE: begin
               // out_data/out_sat keep their values into IDLE.
               if (out_ready) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end

            default: begin
               state_q     <= S_IDLE;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_sla_iter.sv
// -----------------------------------------------------------------------------
// tb_sla_iter -- scoreboard bench for sla_iter (WIDTH=32, SHW=5, STEP=4).
// The stimulus process pushes hand-computed expected results (data, sat flag,
// latency in clocks after the accepting edge) into a queue at the accept; a
// monitor on the falling edge checks every cycle the DUT holds out_valid and
// pops the entry on the handshake.
// -----------------------------------------------------------------------------
module tb_sla_iter;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_shamt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_sat;
   logic        busy;

   sla_iter #(.WIDTH(32), .SHW(5), .STEP(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .busy      (busy)
   );

   typedef struct packed {
      logic [31:0] d;
      logic        s;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        q[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc    = 0;
   int          rise_cyc = 0;
   logic        prev_valid = 1'b0;
   logic        idle_chk   = 1'b0;
   logic [31:0] last_d     = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid = 1'b0;
         idle_chk   = 1'b0;
      end else begin
         if (idle_chk) begin
            check("idle_in_ready", 32'(in_ready), 32'd1);
            check("idle_out_valid", 32'(out_valid), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_hold_data", out_data, last_d);
            idle_chk = 1'b0;
         end
         if (out_valid && !prev_valid) rise_cyc = cyc;
         if (out_valid) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got 0x%08h expected no output", out_data);
            end else begin
               exp_t e;
               e = q[0];
               check("out_data", out_data, e.d);
               check("out_sat", 32'(out_sat), 32'(e.s));
               check("done_in_ready", 32'(in_ready), 32'd0);
               check("done_busy", 32'(busy), 32'd1);
               if (out_ready) begin
                  check("latency", 32'(rise_cyc - e.acc + 1), 32'(e.lat));
                  $display("txn: out_data=0x%08h out_sat=%0d latency=%0d (exp 0x%08h sat=%0d lat=%0d)",
                           out_data, out_sat, rise_cyc - e.acc + 1, e.d, e.s, e.lat);
                  last_d = e.d;
                  void'(q.pop_front());
                  idle_chk = 1'b1;
               end
            end
         end
         prev_valid = out_valid;
      end
   end

   task automatic send(input logic [31:0] d, input logic [4:0] s,
                       input logic [31:0] ed, input logic es, input int lat, input bit push);
      int n = 0;
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_shamt = s;
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1");
         in_valid = 1'b0;
         return;
      end
      if (push) begin
         e.d = ed; e.s = es; e.lat = lat; e.acc = cyc + 1;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = $urandom;
      in_shamt = 5'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got pending=%0d expected 0", q.size());
         q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_shamt  = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_sat", 32'(out_sat), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;

      send(32'h0000_0003, 5'd4, 32'h0000_0030, 1'b0, 2, 1'b1);
      send(32'hFFFF_FFFD, 5'd9, 32'hFFFF_FA00, 1'b0, 4, 1'b1);
      // in_valid wiggling with junk while busy must be ignored
      for (int i = 0; i < 3; i++) begin
         in_valid = ~in_valid;
         in_data  = 32'hDEAD_0000 | 32'(i);
         in_shamt = 5'd7;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      send(32'h4000_0000, 5'd1, 32'h7FFF_FFFF, 1'b1, 2, 1'b1);
      send(32'hC000_0000, 5'd2, 32'h8000_0000, 1'b1, 2, 1'b1);
      send(32'h0000_0001, 5'd31, 32'h7FFF_FFFF, 1'b1, 9, 1'b1);
      send(32'h0000_0000, 5'd31, 32'h0000_0000, 1'b0, 9, 1'b1);
      send(32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b0, 9, 1'b1);
      send(32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFE0, 1'b0, 3, 1'b1);
      send(32'h7FFF_FFFF, 5'd0, 32'h7FFF_FFFF, 1'b0, 1, 1'b1);
      send(32'h8000_0000, 5'd1, 32'h8000_0000, 1'b1, 2, 1'b1);
      send(32'hC000_0000, 5'd1, 32'h8000_0000, 1'b0, 2, 1'b1);
      send(32'h0000_0123, 5'd20, 32'h1230_0000, 1'b0, 6, 1'b1);
      send(32'h1000_0000, 5'd4, 32'h7FFF_FFFF, 1'b1, 2, 1'b1);
      drain();

      // Back-pressure: result must hold while out_ready is low
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      send(32'h1234_5678, 5'd0, 32'h1234_5678, 1'b0, 1, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();

      // Reset in the 2nd shift cycle of a shamt=12 transaction
      send(32'h0000_0001, 5'd12, 32'h0, 1'b0, 0, 1'b0);
      @(posedge clk);
      #2;
      check("midshift_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_out_data", out_data, 32'd0);
      check("arst_out_sat", 32'(out_sat), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      check("post_rst_out_valid", 32'(out_valid), 32'd0);
      send(32'h0000_0001, 5'd3, 32'h0000_0008, 1'b0, 2, 1'b1);
      drain();

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sla_iter.md
Name: sla_iter

Overview:
- Iterative arithmetic shift-left with saturation. The up-scaling counterpart of the IDCT descale right-shifter.
- Used on the forward path (coefficient pre-scaling, fixed-point re-normalisation) between the quantiser interface and the multiply stages.
- Takes one signed WIDTH-bit operand plus a shift amount per transaction over a valid/ready handshake.
- Shifts at most STEP bits per clock, saturates on signed overflow, and returns the result over a second valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result width, two's complement.
- SHW, 5, shift-amount width; legal shift 0..2^SHW-1.
- STEP, 4, maximum bits shifted per SHIFT cycle; 1 <= STEP < WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept operand.
- in_data  in  WIDTH  signed operand.
- in_shamt  in  SHW  left-shift amount.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  WIDTH  shifted/saturated result.
- out_sat  out  1  result was saturated.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Reset (async assert, sync release): state IDLE; out_data=0, out_sat=0, out_valid=0, busy=0, in_ready=1; internal value, remaining count and sign cleared. Reset mid-SHIFT or mid-DONE discards the transaction with no output.
- State IDLE: in_ready=1. When in_valid&in_ready:
  - latch value=in_data, rem=in_shamt, sign=in_data[WIDTH-1], sat=0.
  - If in_shamt==0, go to DONE; otherwise go to SHIFT.
- State SHIFT: in_ready=0, busy=1. Each cycle:
  - k = min(rem, STEP).
  - If sat==0 and the top k+1 bits of value are not all equal (overflow), set sat=1 and force value to the saturation constant: 0x7FFF..F if sign==0, 0x800..0 if sign==1.
  - Otherwise, if sat==0, value = value << k (zeros in).
  - If sat==1 already, value holds.
  - rem = rem-k. When the new rem==0, go to DONE.
- Latency is deterministic. There are N=ceil(shamt/STEP) SHIFT cycles and saturation does not shorten them. out_valid rises N+1 clocks after the accepting edge (1 clock when shamt==0).
- State DONE: out_valid=1, out_data=value, out_sat=sat.
  - Outputs are stable while out_ready=0.
  - On out_valid&out_ready, go to IDLE and deassert out_valid next cycle.
  - out_data/out_sat hold their last values in IDLE.
- No input accept in the DONE cycle: in_ready is asserted only in IDLE. Peak throughput is one transaction per N+2 cycles.
- Boundaries:
  - in_data==0 never saturates; the result is 0 for any shamt.
  - shamt up to 2^SHW-1 is legal. Shifting a nonzero value by >=WIDTH bits always saturates, never wraps.
  - -1 (all ones) shifted by s gives -(2^s) until overflow. -2^(WIDTH-1) is representable; one step further saturates to 0x800..0.
  - in_valid toggling while busy is ignored; in_data/in_shamt are sampled only at the accept edge.
- Width rules: all arithmetic is at WIDTH bits; the overflow check uses the pre-shift value only, with no extended intermediate.

Test Plan:
- in_data=0x00000003, shamt=4, out_ready=1 -> one SHIFT cycle; out_valid 2 clocks after accept; out_data=0x00000030, out_sat=0.
- in_data=0xFFFFFFFD, shamt=9 -> three SHIFT cycles (4,4,1); out_valid 4 clocks after accept; out_data=0xFFFFFA00, out_sat=0.
- in_data=0x40000000, shamt=1 -> out_data=0x7FFFFFFF, out_sat=1. in_data=0xC0000000, shamt=2 -> out_data=0x80000000, out_sat=1. Both with unchanged latency.
- in_data=0x12345678, shamt=0, out_ready held low 5 cycles -> out_valid 1 clock after accept; out_data=0x12345678 stable; in_ready=0 and busy=1 throughout; IDLE on the cycle after out_ready=1.
- in_data=0x00000001, shamt=31 -> 8 SHIFT cycles; out_data=0x7FFFFFFF, out_sat=1. in_data=0, shamt=31 -> out_data=0, out_sat=0.
- Assert rst_n=0 during the 2nd SHIFT cycle of a shamt=12 transaction -> out_valid=0, out_data=0, out_sat=0, busy=0 immediately; in_ready=1 after release; next transaction 0x1, shamt=3 -> 0x00000008.
